// File: rtl/unrank32_sweep.sv
// unrank32_sweep: accepts one 32-bit rank, sweeps unrank32 across N_COLS columns,
// captures each returned row through a latency-matched tag pipeline, and
// presents the packed row vector downstream over a valid/ready handshake.
module unrank32_sweep #(
  parameter int unsigned N_COLS  = 12,
  parameter int unsigned UNR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_num,
  output logic [31:0]           unr_num,
  output logic [5:0]            unr_col,
  input  logic [5:0]            unr_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_num,
  output logic [6*N_COLS-1:0]   out_rows
);

  localparam int unsigned COL_W = 6;
  localparam int unsigned ROW_W = 6;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [COL_W-1:0]  col_d;
  logic              accept_c;
  logic              last_cap_c;

  // Tag pipeline: {valid, col} delayed to line up with the returning row.
  logic [UNR_LAT-1:0] tag_vld;
  logic [COL_W-1:0]   tag_col [UNR_LAT];

  assign accept_c   = (state_q == IDLE) && in_valid;
  assign last_cap_c = tag_vld[UNR_LAT-1] && (tag_col[UNR_LAT-1] == LAST_COL);

  // Next-state and next-column decode.
  always_comb begin
    state_d = state_q;
    col_d   = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = ISSUE;
      end
      ISSUE: begin
        if (unr_col == LAST_COL) begin
          state_d = last_cap_c ? DONE : WAIT;
        end else begin
          col_d = unr_col + COL_W'(1);
        end
      end
      WAIT: begin
        if (last_cap_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered handshake flags and column driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      unr_col   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      unr_col   <= col_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Latch the accepted rank for both the unranker and the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unr_num <= '0;
      out_num <= '0;
    end else if (accept_c) begin
      unr_num <= in_num;
      out_num <= in_num;
    end
  end

  // Shift issued column tags alongside the unranker latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < UNR_LAT; i++) tag_col[i] <= '0;
    end else begin
      tag_vld[0] <= (state_q == ISSUE);
      tag_col[0] <= unr_col;
      for (int unsigned i = 1; i < UNR_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_col[i] <= tag_col[i-1];
      end
    end
  end

  // Write each returning row into the slot named by its emerging tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rows <= '0;
    end else begin
      for (int unsigned k = 0; k < N_COLS; k++) begin
        if (tag_vld[UNR_LAT-1] && (tag_col[UNR_LAT-1] == COL_W'(k))) begin
          out_rows[ROW_W*k +: ROW_W] <= unr_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_unrank32_sweep.sv
// Self-checking bench for unrank32_sweep: a default instance (N_COLS=12, UNR_LAT=1)
// and a small instance (N_COLS=1, UNR_LAT=3), each fed by a behavioural unrank32
// whose row is (num+col) mod 64 after the configured latency.
module tb_unrank32_sweep;

  localparam int unsigned N = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default instance signals.
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_num, unr_num, out_num;
  logic [5:0]    unr_col;
  logic [5:0]    unr_row = '0;
  logic [6*N-1:0] out_rows;

  // Small instance signals.
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0]   b_in_num, b_unr_num, b_out_num;
  logic [5:0]    b_unr_col, b_unr_row, b_out_rows;
  logic [5:0]    b_pipe [3];

  unrank32_sweep dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .unr_num(unr_num), .unr_col(unr_col), .unr_row(unr_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_num(out_num), .out_rows(out_rows)
  );

  unrank32_sweep #(.N_COLS(1), .UNR_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_num(b_in_num),
    .unr_num(b_unr_num), .unr_col(b_unr_col), .unr_row(b_unr_row),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_num(b_out_num), .out_rows(b_out_rows)
  );

  // Behavioural unrank32, one registered stage.
  always @(posedge clk) unr_row <= 6'(unr_num + 32'(unr_col));

  // Behavioural unrank32, three registered stages.
  always @(posedge clk) begin
    b_pipe[0] <= 6'(b_unr_num + 32'(b_unr_col));
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_unr_row = b_pipe[2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6*N-1:0] expect_rows(input logic [31:0] num);
    logic [6*N-1:0] r;
    r = '0;
    for (int k = 0; k < int'(N); k++) r[6*k +: 6] = 6'(num + 32'(k));
    return r;
  endfunction

  // Present a rank from a negedge and return just after its accept edge.
  task automatic send(input logic [31:0] num, input bit hold, input logic [31:0] hold_num,
                      output int waits);
    in_valid = 1'b1;
    in_num   = num;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    if (hold) in_num = hold_num;
    else      in_valid = 1'b0;
  endtask

  // Follow one sweep to DONE, optionally stall, then complete the out handshake.
  task automatic collect(input logic [31:0] num, input int stall, input bit early);
    logic [6*N-1:0] exp;
    int  n;
    bit  seen, busy_ok, col_ok, num_ok, frz_ok;
    logic [5:0] exp_col;
    exp = expect_rows(num);
    out_ready = early;
    n = 0; seen = 0; busy_ok = 1; col_ok = 1; num_ok = 1; frz_ok = 1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1;
      else begin
        exp_col = (n <= int'(N)) ? 6'(n - 1) : 6'd0;
        if (in_ready) busy_ok = 0;
        if (unr_col !== exp_col) col_ok = 0;
        if (unr_num !== num) num_ok = 0;
      end
    end
    check("latency", 128'(n), 128'(N + 2));
    check("in_ready_low_busy", 128'(busy_ok), 128'(1));
    check("unr_col_trace", 128'(col_ok), 128'(1));
    check("unr_num_hold", 128'(num_ok), 128'(1));
    check("out_rows", 128'(out_rows), 128'(exp));
    check("out_num", 128'(out_num), 128'(num));
    check("in_ready_done", 128'(in_ready), 128'(0));
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!out_valid || out_rows !== exp || out_num !== num) frz_ok = 0;
      end
      if (stall > 0) check("stall_frozen", 128'(frz_ok), 128'(1));
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", 128'(out_valid), 128'(0));
    check("in_ready_idle", 128'(in_ready), 128'(1));
    check("unr_num_keep", 128'(unr_num), 128'(num));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  w, n, guard;
    bit  ok;
    logic [31:0] r;
    int  mode;

    rst = 1'b1;
    in_valid = 0; in_num = '0; out_ready = 0;
    b_in_valid = 0; b_in_num = '0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_unr_num", 128'(unr_num), 128'(0));
    check("rst_unr_col", 128'(unr_col), 128'(0));
    check("rst_out_num", 128'(out_num), 128'(0));
    check("rst_out_rows", 128'(out_rows), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic sweep and 6-bit wrap.
    send(32'd0, 0, '0, w);
    collect(32'd0, 0, 0);
    send(32'd60, 0, '0, w);
    collect(32'd60, 0, 0);

    // DONE stall, then back-to-back accept.
    send(32'd100, 0, '0, w);
    collect(32'd100, 10, 0);
    send(32'd5, 0, '0, w);
    check("b2b_accept_wait", 128'(w), 128'(0));
    collect(32'd5, 0, 0);

    // Request held high while busy with a different rank.
    send(32'd200, 1, 32'd777, w);
    collect(32'd200, 0, 0);
    send(32'd777, 0, '0, w);
    check("held_accept_wait", 128'(w), 128'(0));
    collect(32'd777, 0, 0);

    // Reset in the middle of the issue phase.
    send(32'd7, 0, '0, w);
    guard = 0;
    while (unr_col !== 6'd4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reach_col4", 128'(unr_col), 128'(4));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_unr_col", 128'(unr_col), 128'(0));
    check("mid_rst_unr_num", 128'(unr_num), 128'(0));
    check("mid_rst_out_rows", 128'(out_rows), 128'(0));
    check("mid_rst_out_num", 128'(out_num), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) ok = 0;
    end
    check("no_partial_output", 128'(ok), 128'(1));
    send(32'd3, 0, '0, w);
    collect(32'd3, 0, 0);

    // Randomized ranks, gaps, stalls and early out_ready.
    for (int t = 0; t < 16; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = $urandom;
      mode = int'($urandom_range(0, 2));
      send(r, 0, '0, w);
      collect(r, (mode == 1) ? int'($urandom_range(1, 5)) : 0, mode == 2);
    end

    // Small instance: one column, three-cycle unranker.
    b_in_valid = 1'b1;
    b_in_num   = 32'd9;
    guard = 0;
    while (!b_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b_in_ready", 128'(b_in_ready), 128'(1));
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_latency", 128'(n), 128'(5));
    check("b_out_rows", 128'(b_out_rows), 128'(9));
    check("b_out_num", 128'(b_out_num), 128'(9));
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    @(negedge clk);
    check("b_out_valid_drop", 128'(b_out_valid), 128'(0));
    check("b_in_ready_idle", 128'(b_in_ready), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
